// File: rtl/window_minmax_4_if.sv
// Handshake bundle for window_minmax_4. Signal suffixes are from the tracker's point of view.
// MINMAX_INDEX_EN adds the min_idx/max_idx result fields.
interface window_minmax_4_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start_i;
    logic [WIDTH-1:0] din_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] min_o;
    logic [WIDTH-1:0] max_o;
`ifdef MINMAX_INDEX_EN
    logic [7:0]       min_idx_o;
    logic [7:0]       max_idx_o;
`endif
    logic             out_valid_o;
    logic             out_ready_i;
    logic             busy_o;

`ifdef MINMAX_INDEX_EN
    modport slave (
        input  start_i, din_i, in_valid_i, out_ready_i,
        output in_ready_o, min_o, max_o, min_idx_o, max_idx_o, out_valid_o, busy_o
    );
    modport master (
        output start_i, din_i, in_valid_i, out_ready_i,
        input  in_ready_o, min_o, max_o, min_idx_o, max_idx_o, out_valid_o, busy_o
    );
`else
    modport slave (
        input  start_i, din_i, in_valid_i, out_ready_i,
        output in_ready_o, min_o, max_o, out_valid_o, busy_o
    );
    modport master (
        output start_i, din_i, in_valid_i, out_ready_i,
        input  in_ready_o, min_o, max_o, out_valid_o, busy_o
    );
`endif
endinterface

// File: rtl/window_minmax_4.sv
// Windowed min/max tracker: reduces a burst of WIN unsigned samples to their extremes.
// Optional feature macro MINMAX_INDEX_EN: also report the earliest position of each extreme.
module window_minmax_4 #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned WIN   = 8
) (
    input logic               clk,
    input logic               rst_n,
    window_minmax_4_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    localparam logic [7:0] LastCnt = 8'(WIN - 1);

    state_e           state_q;
    logic [7:0]       cnt_q;
    logic [WIDTH-1:0] min_q;
    logic [WIDTH-1:0] max_q;
`ifdef MINMAX_INDEX_EN
    logic [7:0]       min_idx_q;
    logic [7:0]       max_idx_q;
`endif

    // Window FSM with the running extremes held in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            min_q     <= '0;
            max_q     <= '0;
`ifdef MINMAX_INDEX_EN
            min_idx_q <= 8'd0;
            max_idx_q <= 8'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        state_q <= StAcc;
                        cnt_q   <= 8'd0;
                    end
                end
                StAcc: begin
                    if (bus.in_valid_i) begin
                        if (cnt_q == 8'd0) begin
                            min_q     <= bus.din_i;
                            max_q     <= bus.din_i;
`ifdef MINMAX_INDEX_EN
                            min_idx_q <= 8'd0;
                            max_idx_q <= 8'd0;
`endif
                        end else begin
                            // Strict compares keep the earliest occurrence on ties.
                            if (bus.din_i < min_q) begin
                                min_q     <= bus.din_i;
`ifdef MINMAX_INDEX_EN
                                min_idx_q <= cnt_q;
`endif
                            end
                            if (bus.din_i > max_q) begin
                                max_q     <= bus.din_i;
`ifdef MINMAX_INDEX_EN
                                max_idx_q <= cnt_q;
`endif
                            end
                        end
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == LastCnt) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (bus.out_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Handshake outputs decode straight from the state register.
    always_comb begin
        bus.in_ready_o  = (state_q == StAcc);
        bus.out_valid_o = (state_q == StDone);
        bus.busy_o      = (state_q != StIdle);
        bus.min_o       = min_q;
        bus.max_o       = max_q;
`ifdef MINMAX_INDEX_EN
        bus.min_idx_o   = min_idx_q;
        bus.max_idx_o   = max_idx_q;
`endif
    end
endmodule

// File: tb/tb_window_minmax_4.sv
// Randomized bench for window_minmax_4 against a value-level reference model.
module tb_window_minmax_4;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned WIN   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_minmax_4_if #(.WIDTH(WIDTH)) bus ();

    window_minmax_4 #(.WIDTH(WIDTH), .WIN(WIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] samp [WIN];
    int exp_min, exp_max, exp_min_idx, exp_max_idx;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: extremes over the whole window, then the first position holding each.
    task automatic model();
        exp_min = 2 ** WIDTH - 1;
        exp_max = 0;
        foreach (samp[i]) begin
            if (int'(samp[i]) < exp_min) exp_min = int'(samp[i]);
            if (int'(samp[i]) > exp_max) exp_max = int'(samp[i]);
        end
        exp_min_idx = -1;
        exp_max_idx = -1;
        foreach (samp[i]) begin
            if (exp_min_idx < 0 && int'(samp[i]) == exp_min) exp_min_idx = i;
            if (exp_max_idx < 0 && int'(samp[i]) == exp_max) exp_max_idx = i;
        end
    endtask

    task automatic check_result(input string tag);
        check_eq({tag, "_ov"}, 32'(bus.out_valid_o), 32'd1);
        check_eq({tag, "_min"}, 32'(bus.min_o), 32'(exp_min));
        check_eq({tag, "_max"}, 32'(bus.max_o), 32'(exp_max));
`ifdef MINMAX_INDEX_EN
        check_eq({tag, "_min_idx"}, 32'(bus.min_idx_o), 32'(exp_min_idx));
        check_eq({tag, "_max_idx"}, 32'(bus.max_idx_o), 32'(exp_max_idx));
`endif
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_min"}, 32'(bus.min_o), 32'd0);
        check_eq({tag, "_max"}, 32'(bus.max_o), 32'd0);
        check_eq({tag, "_ov"}, 32'(bus.out_valid_o), 32'd0);
        check_eq({tag, "_rdy"}, 32'(bus.in_ready_o), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
`ifdef MINMAX_INDEX_EN
        check_eq({tag, "_min_idx"}, 32'(bus.min_idx_o), 32'd0);
        check_eq({tag, "_max_idx"}, 32'(bus.max_idx_o), 32'd0);
`endif
    endtask

    // gap_mode: 0 continuous, 1 one idle cycle before each sample, 2 random gaps.
    task automatic run_window(input int gap_mode, input int stall, input bit poke);
        @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        check_eq("start_rdy", 32'(bus.in_ready_o), 32'd1);
        check_eq("start_busy", 32'(bus.busy_o), 32'd1);
        for (int i = 0; i < int'(WIN); i++) begin
            int gaps;
            gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (gaps) begin
                bus.in_valid_i = 1'b0;
                bus.din_i      = WIDTH'($urandom);
                @(negedge clk);
            end
            bus.din_i      = samp[i];
            bus.in_valid_i = 1'b1;
            @(negedge clk);
            if (i < int'(WIN) - 1) check_eq("early_ov", 32'(bus.out_valid_o), 32'd0);
        end
        bus.in_valid_i = 1'b0;
        model();
        check_result("res");
        check_eq("done_rdy", 32'(bus.in_ready_o), 32'd0);
        repeat (stall) begin
            bus.din_i       = WIDTH'($urandom);
            bus.in_valid_i  = 1'($urandom);
            bus.start_i     = poke;
            bus.out_ready_i = 1'b0;
            @(negedge clk);
            check_result("hold");
            check_eq("hold_rdy", 32'(bus.in_ready_o), 32'd0);
        end
        bus.in_valid_i  = 1'b0;
        bus.start_i     = poke;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        bus.start_i     = 1'b0;
        check_eq("idle_ov", 32'(bus.out_valid_o), 32'd0);
        check_eq("idle_rdy", 32'(bus.in_ready_o), 32'd0);
        check_eq("idle_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
        check_eq("no_restart", 32'(bus.busy_o), 32'd0);
    endtask

    task automatic load(input logic [31:0] packed_samps);
        for (int i = 0; i < int'(WIN); i++) samp[i] = packed_samps[4*i +: 4];
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.din_i       = '0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;

        // 3,9,1,9,1,15,0,7 (first sample in the low nibble)
        load(32'h70F1_9193);
        run_window(0, 0, 1'b0);
        // All equal
        load(32'h5555_5555);
        run_window(0, 2, 1'b0);
        // Ties 2,8,2,8,...
        load(32'h8282_8282);
        run_window(0, 0, 1'b0);
        // Gapped input, 10-cycle result stall, start poked during DONE
        load(32'h70F1_9193);
        run_window(1, 10, 1'b1);

        // Abort mid-window
        load(32'h70F1_9193);
        @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.din_i      = samp[i];
            bus.in_valid_i = 1'b1;
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_cleared("abort");
        @(negedge clk);
        rst_n = 1'b1;
        load(32'hE1C2_A4B3);
        run_window(0, 0, 1'b0);

        // Random windows; some drawn from a narrow range to force ties
        for (int w = 0; w < 30; w++) begin
            bit narrow;
            narrow = 1'($urandom);
            foreach (samp[i]) samp[i] = narrow ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
            run_window(int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
